booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
Sequential signed multiplier controller built around the 32-bit conditional-invert-and-add datapath.
- Runs radix-2 Booth's algorithm, one add/subtract/no-op step plus an arithmetic right shift per cycle.
- The subtract step drives the invert control and carry-in of the adder path (A + ~M + 1).
- Sits beside the ALU as the multi-cycle unit for mult: start/busy/done handshake, 64-bit {hi, lo} result.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
multiplicand  input  WIDTH  signed operand M; captured on the accepted start
multiplier  input  WIDTH  signed operand Q; captured on the accepted start
busy  output  1  high while iterating (RUN state)
done  output  1  one-cycle pulse; product valid
product_hi  output  WIDTH  upper half of the signed product
product_lo  output  WIDTH  lower half of the signed product
sub_en  output  1  datapath invert/carry-in control for the current step (1 = subtract M)
add_en  output  1  datapath accumulate enable for the current step (1 = add or subtract)

Behaviour:
- Reset: state = IDLE and all internal registers cleared. busy, done, sub_en, add_en = 0; product_hi = product_lo = 0.
- Internal registers:
  - A: WIDTH+1 bits, sign-extended accumulator.
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - M: WIDTH+1 bits, sign-extended.
  - cnt: CNT_W bits.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 → A = 0, Q = multiplier, q_1 = 0, M = sext(multiplicand), cnt = 0; go to RUN.
  - start = 0 → stay in IDLE.
- RUN, one Booth step per cycle, selected by {Q[0], q_1}:
  - 01: A' = A + M (add_en = 1, sub_en = 0).
  - 10: A' = A + ~M + 1 (add_en = 1, sub_en = 1).
  - 00 or 11: A' = A (add_en = 0, sub_en = 0).
  - Then, in the same cycle, arithmetic right shift of {A', Q, q_1}: A[WIDTH] is replicated; A'[0] enters Q[WIDTH-1]; Q[0] enters q_1.
  - cnt increments each step. The cycle that performs step cnt == WIDTH-1 transitions to DONE.
- sub_en / add_en are combinational decodes of {Q[0], q_1} in RUN; 0 in IDLE and DONE.
- DONE:
  - product_hi = A[WIDTH-1:0] and product_lo = Q are registered on the entry edge.
  - done = 1 for exactly one cycle, then unconditionally back to IDLE.
- busy = 1 exactly in RUN, i.e. WIDTH consecutive cycles.
- Latency: start sampled at edge 0 → busy on cycles 1..WIDTH → done high during cycle WIDTH+1 (33 for WIDTH = 32).
- Hold: product_hi/lo hold their value after done until the next accepted start completes. They are not cleared on start.
- Ignored start: start asserted in RUN or DONE is ignored; no queuing. The start must be reasserted in IDLE.
- Width rules: the full signed range is supported, including -2^(WIDTH-1) × -2^(WIDTH-1). The extra accumulator bit prevents overflow. The result is exact 2*WIDTH-bit two's complement.
- Operand changes: changes to multiplicand/multiplier after capture have no effect.
- Reset mid-operation: reset has priority over everything. It aborts RUN or DONE at the next edge, returns to IDLE, clears the outputs, and suppresses the pending done.
- Simultaneous events: reset and start on the same edge → reset wins; the start is dropped.

Test Plan:
- 3 × 5 → done at cycle 33 after start; hi = 0x00000000, lo = 0x0000000F; busy high for exactly 32 cycles.
- -7 (0xFFFFFFF9) × 6 → hi = 0xFFFFFFFF, lo = 0xFFFFFFD6. Check sub_en = 1 on the step where {Q[0], q_1} = 10.
- 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0x00000000. Also -1 × -1 → hi = 0, lo = 1.
- Pulse start again at cycle 10 of a 3 × 5 run, with new operands 2 × 2 → ignored; result still 15; a single done pulse.
- Assert reset at cycle 20 of a run → busy = 0 next cycle, no done, product = 0. A new start 4 × 4 then yields lo = 0x10.
- Back-to-back: start at the first IDLE cycle after done, with -2 × 3 → previous product held until the new done; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/subtract/no-op step plus an
// arithmetic right shift per cycle, with a start/busy/done handshake.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             sub_en,
  output logic             add_en
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH:0]   a_q, m_q;
  logic [WIDTH-1:0] q_q;
  logic             q1_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic [WIDTH:0]   addend_d, a_sum_d, a_d;
  logic [WIDTH-1:0] q_d;
  logic             q1_d;

  // Booth decode of {Q[0], q_1}; only meaningful while iterating.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    sub_en = 1'b0;
    add_en = 1'b0;
    if (state_q == S_RUN) begin
      unique case ({q_q[0], q1_q})
        2'b01:   add_en = 1'b1;
        2'b10: begin
          add_en = 1'b1;
          sub_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Conditional-invert-and-add: subtract is A + ~M + 1 via invert and carry-in.
  always_comb begin
    addend_d = m_q ^ {(WIDTH+1){sub_en}};
    a_sum_d  = add_en ? (a_q + addend_d + {{WIDTH{1'b0}}, sub_en}) : a_q;
    a_d      = {a_sum_d[WIDTH], a_sum_d[WIDTH:1]};
    q_d      = {a_sum_d[0], q_q[WIDTH-1:1]};
    q1_d     = q_q[0];
  end

  always_ff @(posedge clk) begin
    // NOTE: reset clears every register here, including the product holding registers.
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= '0;
            q_q     <= multiplier;
            q1_q    <= 1'b0;
            m_q     <= {multiplicand[WIDTH-1], multiplicand};
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            hi_q    <= a_d[WIDTH-1:0];
            lo_q    <= q_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign product_hi = hi_q;
  assign product_lo = lo_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: a timeline model of the handshake plus plain signed
// multiplication predicts every output each cycle; directed cases pin literals.
module tb_booth_mult_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] mcand = '0;
  logic [W-1:0] mplier = '0;
  logic         busy, done, sub_en, add_en;
  logic [W-1:0] product_hi, product_lo;

  booth_mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo),
    .sub_en       (sub_en),
    .add_en       (add_en)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase timeline, captured operands, product by plain arithmetic.
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_e;
  mphase_e      ph = M_IDLE;
  int           step = 0;
  logic [W-1:0] m_op = '0, q_op = '0;
  logic [63:0]  exp_prod = '0;
  bit           model_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      ph         = M_IDLE;
      exp_prod   = '0;
      model_live = 1'b1;
    end else begin
      case (ph)
        M_IDLE: if (start) begin
          m_op = mcand;
          q_op = mplier;
          step = 0;
          ph   = M_RUN;
        end
        M_RUN: begin
          if (step == W - 1) begin
            exp_prod = 64'(longint'($signed(m_op)) * longint'($signed(q_op)));
            ph       = M_DONE;
          end else begin
            step++;
          end
        end
        M_DONE: ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
    end
  end

  // Step k looks at multiplier bits k and k-1 (bit -1 is 0).
  always @(negedge clk) begin : compare
    logic cur_b, prev_b;
    if (model_live) begin
      cur_b  = (ph == M_RUN) ? q_op[step] : 1'b0;
      prev_b = (ph == M_RUN && step > 0) ? q_op[step-1] : 1'b0;
      check("busy",    busy,    ph == M_RUN);
      check("done",    done,    ph == M_DONE);
      check("sub_en",  sub_en,  cur_b & ~prev_b);
      check("add_en",  add_en,  cur_b ^ prev_b);
      check("product", {product_hi, product_lo}, exp_prod);
    end
  end

  // Starts one multiply from an IDLE negedge, scrambles operands during the run,
  // and optionally re-pulses start (2 x 2) at cycle inject_at.
  task automatic run_mult(input logic [W-1:0] m, input logic [W-1:0] q, input int inject_at,
                          output int lat, output int busy_n, output logic [31:0] sub_trace,
                          output logic [63:0] prod_c1);
    @(negedge clk);
    start = 1'b1;
    mcand = m;
    mplier = q;
    lat = 0;
    busy_n = 0;
    sub_trace = '0;
    prod_c1 = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start  = 1'b0;
      mcand  = $urandom;
      mplier = $urandom;
      if (busy) busy_n++;
      if (n <= 32) sub_trace[n-1] = sub_en;
      if (n == 1) prod_c1 = {product_hi, product_lo};
      if (n == inject_at) begin
        start  = 1'b1;
        mcand  = 32'd2;
        mplier = 32'd2;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, busy_n, dcnt;
    logic [31:0] trace;
    logic [63:0] p1;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sub_add", {sub_en, add_en}, 2'b00);
    check("rst_product", {product_hi, product_lo}, 64'h0);
    reset = 1'b0;

    run_mult(32'd3, 32'd5, 0, lat, busy_n, trace, p1);
    check("3x5_latency", lat, 33);
    check("3x5_busy_cycles", busy_n, 32);
    check("3x5_product", {product_hi, product_lo}, 64'h0000_0000_0000_000F);

    run_mult(32'hFFFF_FFF9, 32'd6, 0, lat, busy_n, trace, p1);
    check("m7x6_hold_prev", p1, 64'h0000_0000_0000_000F);
    check("m7x6_sub_trace", trace, 32'h0000_0002);
    check("m7x6_product", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFD6);

    run_mult(32'h8000_0000, 32'h8000_0000, 0, lat, busy_n, trace, p1);
    check("minxmin_product", {product_hi, product_lo}, 64'h4000_0000_0000_0000);

    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, busy_n, trace, p1);
    check("m1xm1_sub_trace", trace, 32'h0000_0001);
    check("m1xm1_product", {product_hi, product_lo}, 64'h0000_0000_0000_0001);

    run_mult(32'd3, 32'd5, 10, lat, busy_n, trace, p1);
    check("ignored_start_latency", lat, 33);
    check("ignored_start_product", {product_hi, product_lo}, 64'h0000_0000_0000_000F);

    // Reset mid-run, coinciding with a start that must be dropped.
    @(negedge clk);
    start = 1'b1;
    mcand = 32'd3;
    mplier = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    mcand = 32'd9;
    mplier = 32'd9;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_product", {product_hi, product_lo}, 64'h0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("midrst_no_activity", dcnt, 0);

    run_mult(32'd4, 32'd4, 0, lat, busy_n, trace, p1);
    check("4x4_latency", lat, 33);
    check("4x4_product", {product_hi, product_lo}, 64'h0000_0000_0000_0010);

    // Back-to-back: start on the first IDLE cycle after done.
    run_mult(32'hFFFF_FFFE, 32'd3, 0, lat, busy_n, trace, p1);
    check("b2b_hold_prev", p1, 64'h0000_0000_0000_0010);
    check("b2b_latency", lat, 33);
    check("b2b_product", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom % 3) @(negedge clk);
      run_mult(pick(), pick(), ($urandom % 4 == 0) ? int'($urandom_range(1, 32)) : 0,
               lat, busy_n, trace, p1);
      check("rand_latency", lat, 33);
      check("rand_busy_cycles", busy_n, 32);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
